cond_unit_mt: RTL

- Parametrised successor to the single-thread ARM-style condition logic in the control unit.
- Holds NZCV flags per hardware context (NUM_CTX banks) and evaluates the 4-bit condition field against the flags of the selected context.
- Gates PCSrc, RegWrite, MemWrite and flag writes for that context.
- Adds predicated-block mode: a header instruction applies one extra condition to the next N instructions of the same context.

---
 rtl/cond_unit_mt.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cond_unit_mt.sv
// Multi-context NZCV condition unit with predicated-block mode.
// Optional annul counter enabled by defining COND_STATS_EN.
module cond_unit_mt #(
  parameter int NUM_CTX = 2,
  parameter int LEN_W   = 3,
  localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [CTX_W-1:0] ctx_id,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             blk_start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [3:0]       blk_cond,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic             blk_active
`ifdef COND_STATS_EN
  ,
  output logic [15:0]      annul_cnt
`endif
);

  function automatic logic dec(input logic [3:0] c,
                               input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    {n, z, cy, v} = f;
    unique case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]       flags_q [NUM_CTX];
  logic [3:0]       flags_d [NUM_CTX];
  logic [LEN_W-1:0] cnt_q   [NUM_CTX];
  logic [LEN_W-1:0] cnt_d   [NUM_CTX];
  logic [3:0]       bcond_q [NUM_CTX];
  logic [3:0]       bcond_d [NUM_CTX];

  logic             fire;
  logic             ctx_ok;
  logic [3:0]       cur_f;
  logic [LEN_W-1:0] cur_cnt;
  logic [3:0]       cur_bc;
  logic             pass_c;
  logic             blk_ok;
  logic             cond_ex;
  logic             wr_en;

  // Select the current context's state and evaluate the condition
  always_comb begin
    fire    = in_valid & ~stall;
    ctx_ok  = 1'b0;
    cur_f   = '0;
    cur_cnt = '0;
    cur_bc  = 4'b1110;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (ctx_id == CTX_W'(i)) begin
        ctx_ok  = 1'b1;
        cur_f   = flags_q[i];
        cur_cnt = cnt_q[i];
        cur_bc  = bcond_q[i];
      end
    end
    pass_c  = dec(Cond, cur_f);
    blk_ok  = (cur_cnt == '0) | dec(cur_bc, cur_f);
    cond_ex = fire & ctx_ok & pass_c & (blk_start | blk_ok);
    wr_en   = cond_ex & ~blk_start;
  end

  // Outputs are held low while reset is asserted
  always_comb begin
    PCSrc      = reset & PCS & wr_en;
    RegWrite   = reset & RegW & wr_en;
    MemWrite   = reset & MemW & wr_en;
    CondEx     = reset & cond_ex;
    Flags      = reset ? cur_f : 4'b0000;
    blk_active = reset & (cur_cnt != '0);
  end

  // Next state: only the bank of the firing context may change
  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      flags_d[i] = flags_q[i];
      cnt_d[i]   = cnt_q[i];
      bcond_d[i] = bcond_q[i];
      if (fire && ctx_ok && ctx_id == CTX_W'(i)) begin
        if (blk_start) begin
          if (pass_c) begin
            cnt_d[i]   = blk_len;
            bcond_d[i] = blk_cond;
          end
        end else begin
          if (cond_ex && FlagW[1])
            flags_d[i][3:2] = ALUFlags[3:2];
          if (cond_ex && FlagW[0])
            flags_d[i][1:0] = ALUFlags[1:0];
          if (cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - LEN_W'(1);
        end
      end
    end
  end

  // Per-context flag and block state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        flags_q[i] <= 4'b0000;
        cnt_q[i]   <= '0;
        bcond_q[i] <= 4'b1110;
      end
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      bcond_q <= bcond_d;
    end
  end

`ifdef COND_STATS_EN
  logic [15:0] annul_q;
  logic [15:0] annul_d;

  // Count fired non-header instructions that were annulled
  always_comb begin
    annul_d = annul_q;
    if (fire && !blk_start && !cond_ex && annul_q != 16'hFFFF)
      annul_d = annul_q + 16'd1;
  end

  // Saturating annul counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      annul_q <= '0;
    else
      annul_q <= annul_d;
  end

  assign annul_cnt = annul_q;
`endif

endmodule
